// File: rtl/cache_pkg.sv
// Shared definitions for the cache port arbiter slice.
// Contents:
//   id_width()   - requester-ID width for a given requester count (at least 1 bit)
//   REQ_ID_W     - ID width for the default requester count
//   cache_req_t  - one requester's request fields, used to unpack the flattened ports
package cache_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int WMASK_W_DEF = 4;

  // Requester-ID width; a single requester still needs one bit of ID.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int REQ_ID_W = id_width(NUM_REQ_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  addr;
    logic                   web;
    logic [DATA_W_DEF-1:0]  wdat;
    logic [WMASK_W_DEF-1:0] wmask;
  } cache_req_t;

endpackage

// File: rtl/cache_arb_id_fifo.sv
// In-order FIFO holding the requester ID of every read in flight.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   push, din   - write an entry (ignored when full)
//   pop, dout   - drop the head entry (ignored when empty); dout is the head
//   count       - number of stored entries, 0..DEPTH
//   full, empty - occupancy flags
module cache_arb_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; push and pop in one cycle leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_port_arb.sv
// Round-robin arbiter sharing the cache controller's upstream port 0 among
// NUM_REQ requesters, with in-order steering of read data back to the issuer.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   req_vld_i/req_rdy_o        - per-requester request handshake
//   req_addr_i/web/wdat/wmask  - flattened per-requester request fields (slice i = requester i)
//   rsp_vld_o/rsp_rdy_i        - per-requester read-data handshake
//   rsp_dat_o                  - read data, broadcast to every requester
//   p0_uvld_o/p0_urdy_i, p0_addr_o/web/wdat/wmask - request toward the cache
//   p0_dvld_i/p0_drdy_o, p0_ddat_i                - read data from the cache
//   err_o                      - sticky: read data arrived with no read outstanding
module cache_port_arb
  import cache_pkg::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int ADDR_WIDTH      = ADDR_W_DEF,
  parameter int DATA_WIDTH      = DATA_W_DEF,
  parameter int WMASK_WIDTH     = WMASK_W_DEF,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_vld_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]             req_web_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdat_i,
  input  logic [NUM_REQ*WMASK_WIDTH-1:0] req_wmask_i,
  output logic [NUM_REQ-1:0]             rsp_vld_o,
  input  logic [NUM_REQ-1:0]             rsp_rdy_i,
  output logic [DATA_WIDTH-1:0]          rsp_dat_o,
  output logic                           p0_uvld_o,
  input  logic                           p0_urdy_i,
  output logic [ADDR_WIDTH-1:0]          p0_addr_o,
  output logic                           p0_web_o,
  output logic [DATA_WIDTH-1:0]          p0_wdat_o,
  output logic [WMASK_WIDTH-1:0]         p0_wmask_o,
  input  logic                           p0_dvld_i,
  output logic                           p0_drdy_o,
  input  logic [DATA_WIDTH-1:0]          p0_ddat_i,
  output logic                           err_o
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    lock_id;
  logic               lock;
  logic               err;
  logic [ID_W-1:0]    gnt;
  logic               found;
  logic [NUM_REQ-1:0] eligible;
  cache_req_t         reqs [NUM_REQ];
  cache_req_t         sel;
  logic               accept;
  logic               push;
  logic               pop;
  logic [ID_W-1:0]    head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               has_rd;

  // Unpack the flattened request slices; a read is eligible only while the ID FIFO has room.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i].addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      reqs[i].web   = req_web_i[i];
      reqs[i].wdat  = req_wdat_i[i*DATA_WIDTH +: DATA_WIDTH];
      reqs[i].wmask = req_wmask_i[i*WMASK_WIDTH +: WMASK_WIDTH];
      eligible[i]   = req_vld_i[i] & (~req_web_i[i] | ~fifo_full);
    end
  end

  // Grant selection: hold the locked requester, else first eligible scanning up from rr_ptr.
  always_comb begin
    int   idx;
    logic pick;
    gnt   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    pick  = 1'b0;
    if (lock) begin
      gnt   = lock_id;
      found = req_vld_i[lock_id];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx   = int'(rr_ptr) + k;
        idx   = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
        pick  = ~found & eligible[idx];
        gnt   = pick ? ID_W'(idx) : gnt;
        found = found | pick;
      end
    end
  end

  // Zero-latency request path and in-order response steering; all handshakes held low in reset.
  always_comb begin
    sel        = reqs[gnt];
    p0_uvld_o  = ~reset & found;
    p0_addr_o  = sel.addr;
    p0_web_o   = sel.web;
    p0_wdat_o  = sel.wdat;
    p0_wmask_o = sel.wmask;
    req_rdy_o  = {NUM_REQ{1'b0}};
    req_rdy_o[gnt] = p0_uvld_o & p0_urdy_i;
    accept     = p0_uvld_o & p0_urdy_i;
    push       = accept & sel.web;

    has_rd     = (fifo_count != {CNT_W{1'b0}});
    rsp_vld_o  = {NUM_REQ{1'b0}};
    rsp_vld_o[head] = ~reset & p0_dvld_i & has_rd;
    // With nothing outstanding the beat is drained rather than stalling the cache.
    p0_drdy_o  = ~reset & (has_rd ? rsp_rdy_i[head] : 1'b1);
    pop        = p0_dvld_i & p0_drdy_o & has_rd;
    rsp_dat_o  = p0_ddat_i;
  end

  // Round-robin pointer, grant lock and sticky orphan-data error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= {ID_W{1'b0}};
      lock    <= 1'b0;
      lock_id <= {ID_W{1'b0}};
      err     <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (gnt == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : gnt + ID_W'(1);
      end
      if (p0_uvld_o && !p0_urdy_i) begin
        lock    <= 1'b1;
        lock_id <= gnt;
      end else if (accept) begin
        lock    <= 1'b0;
      end
      err <= err | (p0_dvld_i & fifo_empty);
    end
  end

  assign err_o = err;

  cache_arb_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (gnt),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/cache_port_arb.md
Name: cache_port_arb

Overview:
- Shares the cache controller's single upstream port 0 between NUM_REQ requesters, e.g. instruction fetch and load/store.
- Round-robin arbitration on the request side; the grant is locked while a presented request waits for acceptance.
- Each read's requester ID is recorded in an in-order FIFO so read data returning on port 0 is steered back to the correct requester.
- Sits directly between the core-side requesters and the cache controller p0 upstream/downstream interfaces.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data word width.
- WMASK_WIDTH, 4, byte-mask width.
- MAX_OUTSTANDING, 4, maximum in-flight reads (ID FIFO depth, power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_vld_i  in  NUM_REQ  per-requester request valid.
- req_rdy_o  out  NUM_REQ  per-requester request accepted.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at slice i.
- req_web_i  in  NUM_REQ  write-enable-bar; 1 = read, 0 = write.
- req_wdat_i  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_wmask_i  in  NUM_REQ*WMASK_WIDTH  flattened byte masks.
- rsp_vld_o  out  NUM_REQ  per-requester read data valid.
- rsp_rdy_i  in  NUM_REQ  per-requester read data ready.
- rsp_dat_o  out  DATA_WIDTH  read data, broadcast to all requesters.
- p0_uvld_o  out  1  valid toward cache upstream port.
- p0_urdy_i  in  1  cache upstream ready.
- p0_addr_o  out  ADDR_WIDTH  address toward cache.
- p0_web_o  out  1  write-enable-bar toward cache.
- p0_wdat_o  out  DATA_WIDTH  write data toward cache.
- p0_wmask_o  out  WMASK_WIDTH  byte mask toward cache.
- p0_dvld_i  in  1  cache read data valid.
- p0_drdy_o  out  1  ready toward cache downstream port.
- p0_ddat_i  in  DATA_WIDTH  cache read data.
- err_o  out  1  sticky error: read data arrived with no outstanding read.

Behaviour:
- Reset: rr_ptr=0, lock=0, ID FIFO empty (count=0), err_o=0. While reset is high, p0_uvld_o, req_rdy_o, rsp_vld_o and p0_drdy_o are forced to 0. Reset mid-transaction drops all in-flight IDs; any data the cache returns later sets err_o.
- Eligibility: requester i is eligible when req_vld_i[i] and (req_web_i[i]==0 or count<MAX_OUTSTANDING). Writes are never blocked by a full FIFO. There is no bypass: a read at count==MAX waits even if a pop occurs that cycle.
- Arbitration:
  - Unlocked: grant the first eligible requester scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Locked: the grant stays on lock_id, whether or not it is still eligible.
  - The request path is combinational, zero latency: p0_uvld_o = granted valid; p0 addr/web/wdat/wmask are muxed from the granted requester; req_rdy_o[g] = p0_urdy_i, all other bits 0.
- Lock: set when p0_uvld_o && !p0_urdy_i, with lock_id = g; cleared on acceptance. This prevents the presented request changing before the cache accepts it.
- Acceptance (p0_uvld_o && p0_urdy_i): rr_ptr <= (g+1) mod NUM_REQ. If p0_web_o==1, push g into the ID FIFO.
- Responses (in order): head = FIFO head ID.
  - rsp_vld_o[head] = p0_dvld_i && count!=0; all other bits 0.
  - p0_drdy_o = rsp_rdy_i[head] when count!=0.
  - Pop on p0_dvld_i && p0_drdy_o.
- Empty FIFO with p0_dvld_i=1: p0_drdy_o=1 (drain the beat), no rsp_vld_o, err_o <= 1 until reset.
- Simultaneous push and pop: count unchanged, pointers both advance. Count width is $clog2(MAX_OUTSTANDING)+1.
- Writes generate no response and no FIFO entry.

Decomposition:
- Shared package cache_pkg:
  - localparam REQ_ID_W = $clog2(NUM_REQ) (minimum 1).
  - typedef cache_req_t {addr, web, wdat, wmask}, used for the flattened-slice unpack.
- Sub-module cache_arb_id_fifo: synchronous FIFO with parameters WIDTH and DEPTH; ports push/pop/din/dout/count/full/empty; async reset.
- The arbiter core (rr_ptr, lock, mux) stays in cache_port_arb.

Test Plan:
- Both requesters issue back-to-back reads, p0_urdy_i=1 with NUM_REQ=2: grants alternate 0,1,0,1; returned data 0xA0,0xA1,0xA2,0xA3 appears on rsp_vld_o[0],[1],[0],[1] in that order.
- Requester 1 read presented, p0_urdy_i held 0 for 3 cycles while requester 0 raises valid: p0_addr_o is stable at req 1's address for all 3 cycles; req_rdy_o[0]=0; grant moves to 0 the cycle after acceptance.
- Five reads from requester 0, no responses, MAX_OUTSTANDING=4: the 5th read stalls (req_rdy_o[0]=0); a write from requester 1 is still accepted; after one response pops, the 5th read is accepted the next cycle.
- Response backpressure: head ID=1, rsp_rdy_i[1]=0 for 2 cycles: p0_drdy_o=0 for 2 cycles and count is unchanged; the pop occurs on the cycle rsp_rdy_i[1] rises.
- p0_dvld_i=1 with an empty FIFO: p0_drdy_o=1, rsp_vld_o=0, err_o goes 1 next cycle and stays 1 until reset.
- Reset asserted with 3 reads in flight: all outputs 0 immediately (async); after release count=0, rr_ptr=0, err_o=0.
